// File: rtl/vector_cache_pkg.sv
// Shared vector-cache types: RAM payloads and the read-side bank-to-channel map.
package vector_cache_pkg;

    localparam int unsigned RD_NUM_BANKS = 8;
    localparam int unsigned RD_NUM_CH    = 4;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } write_ram_pld_t;

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] data;
    } read_ram_pld_t;

    // Bank k feeds channel k>>1; bit 0 of the bank id picks even/odd slot order.
    localparam int unsigned RD_BANK_TO_CH [RD_NUM_BANKS] = '{0, 0, 1, 1, 2, 2, 3, 3};

endpackage

// File: rtl/rd_merge_fifo.sv
// Per-channel FIFO taking up to two pushes (even bank first) and one pop per cycle.
// Beats that do not fit are dropped and flagged by a sticky overflow bit.
module rd_merge_fifo
    import vector_cache_pkg::*;
#(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AFULL_LVL = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_even_i,
    input  read_ram_pld_t pld_even_i,
    input  logic          push_odd_i,
    input  read_ram_pld_t pld_odd_i,
    input  logic          pop_rdy_i,
    output logic          vld_o,
    output read_ram_pld_t pld_o,
    output logic          afull_o,
    output logic          ovf_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          afull_q, afull_d;
    logic          ovf_q, ovf_d;

    read_ram_pld_t mem_q [DEPTH];

    logic          pop;
    logic [CW-1:0] free_w;
    logic          acc_even;
    logic          acc_odd;
    logic [1:0]    n_acc;
    logic          wr0_en;
    logic          wr1_en;
    logic [PW-1:0] wr0_idx;
    logic [PW-1:0] wr1_idx;
    read_ram_pld_t wr0_pld;

    always_comb begin
        pop      = (cnt_q != '0) && pop_rdy_i;
        // A same-cycle pop releases its slot to this cycle's pushes.
        free_w   = CW'(DEPTH) - cnt_q + CW'(pop);
        acc_even = push_even_i && (free_w != '0);
        acc_odd  = push_odd_i && (free_w >= (push_even_i ? CW'(2) : CW'(1)));
        n_acc    = {1'b0, acc_even} + {1'b0, acc_odd};

        wr0_en   = acc_even || acc_odd;
        wr0_idx  = wr_ptr_q;
        wr0_pld  = acc_even ? pld_even_i : pld_odd_i;
        wr1_en   = acc_even && acc_odd;
        wr1_idx  = wr_ptr_q + PW'(1);

        wr_ptr_d = wr_ptr_q + PW'(n_acc);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        cnt_d    = cnt_q + CW'(n_acc) - CW'(pop);
        afull_d  = (CW'(DEPTH) - cnt_d) < CW'(AFULL_LVL);
        ovf_d    = ovf_q || (push_even_i && !acc_even) || (push_odd_i && !acc_odd);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            afull_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            afull_q  <= afull_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (wr0_en) mem_q[wr0_idx] <= wr0_pld;
        if (wr1_en) mem_q[wr1_idx] <= pld_odd_i;
    end

    assign vld_o   = (cnt_q != '0);
    assign pld_o   = mem_q[rd_ptr_q];
    assign afull_o = afull_q;
    assign ovf_o   = ovf_q;

endmodule

// File: rtl/read_data_sel.sv
// Merges eight RAM read banks of one direction into four requester channels.
// One instance serves each of the west, east, south and north directions.
module read_data_sel
    import vector_cache_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned AFULL_LVL  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic          [7:0] ram_rd_vld,
    input  read_ram_pld_t [7:0] ram_rd_pld,
    output logic          [3:0] rd_data_vld,
    output read_ram_pld_t [3:0] rd_data_pld,
    input  logic          [3:0] rd_data_rdy,
    output logic          [3:0] ch_afull,
    output logic          [3:0] ovf_err
);

    logic          [RD_NUM_CH-1:0][1:0] bank_vld;
    read_ram_pld_t [RD_NUM_CH-1:0][1:0] bank_pld;

    for (genvar k = 0; k < RD_NUM_BANKS; k++) begin : g_bank
        assign bank_vld[RD_BANK_TO_CH[k]][k % 2] = ram_rd_vld[k];
        assign bank_pld[RD_BANK_TO_CH[k]][k % 2] = ram_rd_pld[k];
    end

    for (genvar i = 0; i < RD_NUM_CH; i++) begin : g_ch
        rd_merge_fifo #(
            .DEPTH     (FIFO_DEPTH),
            .AFULL_LVL (AFULL_LVL)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .push_even_i (bank_vld[i][0]),
            .pld_even_i  (bank_pld[i][0]),
            .push_odd_i  (bank_vld[i][1]),
            .pld_odd_i   (bank_pld[i][1]),
            .pop_rdy_i   (rd_data_rdy[i]),
            .vld_o       (rd_data_vld[i]),
            .pld_o       (rd_data_pld[i]),
            .afull_o     (ch_afull[i]),
            .ovf_o       (ovf_err[i])
        );
    end

endmodule

// File: tb/tb_read_data_sel.sv
// Directed checks of read_data_sel with FIFO_DEPTH=4, AFULL_LVL=2.
module tb_read_data_sel;
    import vector_cache_pkg::*;

    logic                clk;
    logic                rst;
    logic          [7:0] ram_rd_vld;
    read_ram_pld_t [7:0] ram_rd_pld;
    logic          [3:0] rd_data_vld;
    read_ram_pld_t [3:0] rd_data_pld;
    logic          [3:0] rd_data_rdy;
    logic          [3:0] ch_afull;
    logic          [3:0] ovf_err;

    int vectors;
    int miscompares;

    read_data_sel #(.FIFO_DEPTH(4), .AFULL_LVL(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .ram_rd_vld  (ram_rd_vld),
        .ram_rd_pld  (ram_rd_pld),
        .rd_data_vld (rd_data_vld),
        .rd_data_pld (rd_data_pld),
        .rd_data_rdy (rd_data_rdy),
        .ch_afull    (ch_afull),
        .ovf_err     (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic read_ram_pld_t mk(input logic [7:0] t);
        read_ram_pld_t p;
        p.tag  = t;
        p.data = {~t, t, 8'h5A, t};
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_bank(input int k, input read_ram_pld_t v);
        ram_rd_vld    = 8'(1) << k;
        ram_rd_pld[k] = v;
        tick();
        ram_rd_vld    = 8'h00;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        ram_rd_vld  = 8'h00;
        ram_rd_pld  = '0;
        rd_data_rdy = 4'h0;
        tick();
        tick();
        chk("rst_vld",   64'(rd_data_vld), 64'(4'h0));
        chk("rst_afull", 64'(ch_afull),    64'(4'h0));
        chk("rst_ovf",   64'(ovf_err),     64'(4'h0));
        rst = 1'b0;
        tick();

        // Single beat on bank 2, empty FIFO with rdy high: push stored, no pop.
        rd_data_rdy   = 4'hF;
        ram_rd_vld    = 8'h04;
        ram_rd_pld[2] = mk(8'hA0);
        #1;
        chk("single_no_comb", 64'(rd_data_vld), 64'(4'h0));
        tick();
        ram_rd_vld = 8'h00;
        chk("single_vld", 64'(rd_data_vld),    64'(4'b0010));
        chk("single_pld", 64'(rd_data_pld[1]), 64'(mk(8'hA0)));
        tick();
        chk("single_drained", 64'(rd_data_vld), 64'(4'h0));

        // Dual push on banks 6/7: even first.
        ram_rd_vld    = 8'hC0;
        ram_rd_pld[6] = mk(8'hB0);
        ram_rd_pld[7] = mk(8'hC0);
        tick();
        ram_rd_vld = 8'h00;
        chk("dual_vld0", 64'(rd_data_vld),    64'(4'b1000));
        chk("dual_pldB", 64'(rd_data_pld[3]), 64'(mk(8'hB0)));
        tick();
        chk("dual_vld1", 64'(rd_data_vld),    64'(4'b1000));
        chk("dual_pldC", 64'(rd_data_pld[3]), 64'(mk(8'hC0)));
        tick();
        chk("dual_drained", 64'(rd_data_vld), 64'(4'h0));

        // Backpressure on channel 0 and the afull crossing at count 3.
        rd_data_rdy = 4'b1110;
        push_bank(0, mk(8'hD0));
        chk("bp_afull1", 64'(ch_afull[0]),    64'(1'b0));
        chk("bp_pld1",   64'(rd_data_pld[0]), 64'(mk(8'hD0)));
        push_bank(0, mk(8'hD1));
        chk("bp_afull2", 64'(ch_afull[0]),    64'(1'b0));
        chk("bp_pld2",   64'(rd_data_pld[0]), 64'(mk(8'hD0)));
        push_bank(0, mk(8'hD2));
        chk("bp_afull3", 64'(ch_afull[0]),    64'(1'b1));
        chk("bp_vld3",   64'(rd_data_vld),    64'(4'b0001));
        chk("bp_pld3",   64'(rd_data_pld[0]), 64'(mk(8'hD0)));
        rd_data_rdy = 4'hF;
        tick();
        chk("bp_drain1",  64'(rd_data_pld[0]), 64'(mk(8'hD1)));
        chk("bp_afull_c", 64'(ch_afull[0]),    64'(1'b0));
        tick();
        chk("bp_drain2", 64'(rd_data_pld[0]), 64'(mk(8'hD2)));
        tick();
        chk("bp_empty", 64'(rd_data_vld), 64'(4'h0));

        // Overflow on channel 1: three held, dual push keeps bank 2 and drops bank 3.
        rd_data_rdy = 4'b1101;
        push_bank(2, mk(8'hE0));
        push_bank(2, mk(8'hE1));
        push_bank(2, mk(8'hE2));
        chk("ovf_pre", 64'(ovf_err), 64'(4'h0));
        ram_rd_vld    = 8'h0C;
        ram_rd_pld[2] = mk(8'hE3);
        ram_rd_pld[3] = mk(8'hE4);
        tick();
        ram_rd_vld = 8'h00;
        chk("ovf_set",   64'(ovf_err),     64'(4'b0010));
        chk("ovf_afull", 64'(ch_afull[1]), 64'(1'b1));
        rd_data_rdy = 4'hF;
        chk("ovf_d0", 64'(rd_data_pld[1]), 64'(mk(8'hE0)));
        tick();
        chk("ovf_d1", 64'(rd_data_pld[1]), 64'(mk(8'hE1)));
        tick();
        chk("ovf_d2", 64'(rd_data_pld[1]), 64'(mk(8'hE2)));
        tick();
        chk("ovf_d3", 64'(rd_data_pld[1]), 64'(mk(8'hE3)));
        tick();
        chk("ovf_empty",  64'(rd_data_vld), 64'(4'h0));
        chk("ovf_sticky", 64'(ovf_err),     64'(4'b0010));

        // Channel 0 full, pop plus dual push: one slot freed, even beat kept.
        rd_data_rdy = 4'b1110;
        push_bank(0, mk(8'hF0));
        push_bank(0, mk(8'hF1));
        push_bank(0, mk(8'hF2));
        push_bank(0, mk(8'hF3));
        chk("full_afull", 64'(ch_afull[0]), 64'(1'b1));
        rd_data_rdy   = 4'hF;
        ram_rd_vld    = 8'h03;
        ram_rd_pld[0] = mk(8'hF4);
        ram_rd_pld[1] = mk(8'hF5);
        tick();
        ram_rd_vld  = 8'h00;
        rd_data_rdy = 4'b1110;
        chk("full_ovf",   64'(ovf_err),        64'(4'b0011));
        chk("full_afull2",64'(ch_afull[0]),    64'(1'b1));
        chk("full_head",  64'(rd_data_pld[0]), 64'(mk(8'hF1)));
        rd_data_rdy = 4'hF;
        tick();
        chk("full_d2", 64'(rd_data_pld[0]), 64'(mk(8'hF2)));
        tick();
        chk("full_d3", 64'(rd_data_pld[0]), 64'(mk(8'hF3)));
        tick();
        chk("full_d4", 64'(rd_data_pld[0]), 64'(mk(8'hF4)));
        tick();
        chk("full_empty", 64'(rd_data_vld), 64'(4'h0));

        // Reset with two beats queued on channel 2.
        rd_data_rdy = 4'h0;
        push_bank(4, mk(8'h10));
        push_bank(4, mk(8'h11));
        chk("rstm_pre", 64'(rd_data_vld), 64'(4'b0100));
        rst = 1'b1;
        tick();
        chk("rstm_vld", 64'(rd_data_vld), 64'(4'h0));
        chk("rstm_ovf", 64'(ovf_err),     64'(4'h0));
        chk("rstm_afl", 64'(ch_afull),    64'(4'h0));
        rst         = 1'b0;
        rd_data_rdy = 4'hF;
        tick();
        chk("rstm_stale1", 64'(rd_data_vld), 64'(4'h0));
        tick();
        chk("rstm_stale2", 64'(rd_data_vld), 64'(4'h0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/read_data_sel.md
READ_DATA_SEL -- requirements
Module: read_data_sel

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries per channel FIFO; power of two, at least 2.
REQ-002 Parameter AFULL_LVL, default 2: free-entry count below which ch_afull asserts.
REQ-003 clk  input  1  block clock; single clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ram_rd_vld  input  [7:0]  read-data valid from RAM bank k of one direction; no backpressure.
REQ-006 ram_rd_pld  input  read_ram_pld_t [7:0]  read-data payload from RAM bank k.
REQ-007 rd_data_vld  output  [3:0]  channel i read data valid toward the requester.
REQ-008 rd_data_pld  output  read_ram_pld_t [3:0]  channel i read-data payload.
REQ-009 rd_data_rdy  input  [3:0]  requester accepts channel i.
REQ-010 ch_afull  output  [3:0]  channel i free entries < AFULL_LVL; read-command issue for channel i is throttled by this.
REQ-011 ovf_err  output  [3:0]  sticky: channel i dropped a beat.

Function
REQ-012 Banks 2i (even) and 2i+1 (odd) SHALL merge into channel i, the inverse of the write-side dest_ram_id[0] split.
REQ-013 Each channel SHALL own one FIFO of FIFO_DEPTH entries that accepts 0, 1 or 2 pushes per cycle.
REQ-014 When both banks are valid in one cycle, the even bank SHALL be written before the odd bank, at consecutive slots.
REQ-015 A push at cycle N SHALL be visible on rd_data_vld/pld at N+1 at the earliest; there is no combinational input-to-output path.
REQ-016 rd_data_vld[i] SHALL equal (count[i] != 0), and rd_data_pld[i] SHALL be the head entry.
REQ-017 A pop occurs when rd_data_vld[i] && rd_data_rdy[i].
REQ-018 rd_data_pld SHALL hold stable while vld is high and rdy is low.
REQ-019 Count update: count_next = count + pushes - pop.
REQ-020 The count SHALL be log2(FIFO_DEPTH)+1 bits.
REQ-021 Read and write pointers SHALL be log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-022 A pop in the same cycle SHALL free a slot for that cycle's pushes: free = FIFO_DEPTH - count + pop.
REQ-023 Overflow: if pushes exceed free, the even beat SHALL be kept when one slot is free, and the excess beat(s) dropped.
REQ-024 On overflow, ovf_err[i] SHALL be set, and FIFO contents and pointers SHALL stay consistent.
REQ-025 ovf_err SHALL clear only on reset.
REQ-026 Empty with a simultaneous push and pop request: no pop occurs (vld is low), and the push is stored.
REQ-027 ch_afull[i] SHALL be registered from count_next, so it asserts the cycle after the push that crosses the threshold.
REQ-028 Channels SHALL be fully independent; no cross-channel arbitration.

Reset
REQ-029 While rst is high, at every clk edge: pointers = 0, count = 0, rd_data_vld = 0, ch_afull = 0, ovf_err = 0.
REQ-030 Assertion of rst mid-operation SHALL discard all buffered beats; nothing SHALL be emitted after reset that was pushed before it.
REQ-031 FIFO storage SHALL need no reset; rd_data_pld is don't-care while vld is 0.

Structure
REQ-032 read_ram_pld_t SHALL be defined in vector_cache_pkg alongside write_ram_pld_t.
REQ-033 The bank-to-channel mapping constant (bank k maps to channel k>>1) SHALL be defined in vector_cache_pkg alongside write_ram_pld_t.
REQ-034 One sub-module, rd_merge_fifo (2-push, 1-pop FIFO), SHALL be instantiated 4 times.
REQ-035 read_data_sel SHALL be instantiated once per direction: west, east, south, north.

Verification
REQ-036 Single beat: ram_rd_vld=8'h04, pld A -> rd_data_vld=4'b0010 next cycle with pld A; rdy=1 pops it; vld=0 the cycle after.
REQ-037 Dual push: banks 6 and 7 valid together (B, C), rdy=1 -> channel 3 emits B then C on consecutive cycles.
REQ-038 Backpressure/afull: rdy[0]=0, bank 0 pushes 3 beats -> count=3, ch_afull[0]=1 after the crossing push; pld stable; releasing rdy drains in order.
REQ-039 Overflow: depth 4, channel 1 holding 3, banks 2 and 3 push together, no pop -> bank 2 beat stored, bank 3 beat dropped, ovf_err[1]=1 sticky.
REQ-040 Full with pop plus dual push: count=4, rdy=1, banks 0 and 1 push -> count=5 rejected; count=4 with even beat kept and ovf_err[0] set.
REQ-041 Reset mid-stream: rst pulsed with 2 beats queued -> vld=0 next cycle, no stale beat emitted, ovf_err=0.
